// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial pattern detector (MSB-first, KMP fallback), with a
// qualifying valid, a synchronous clear and an optional saturating match counter (SEQDET_MATCH_CNT_EN).
module mealy_seq_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din,
  input  logic                       din_valid,
  input  logic                       clr,
  output logic                       dout,
  output logic [$clog2(PAT_LEN)-1:0] state_o,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int          SW     = $clog2(PAT_LEN);
  localparam int          NSTATE = 1 << SW;
  localparam logic [15:0] PAT16  = 16'(PATTERN);

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_ADVANCE,
    STEP_FALLBACK,
    STEP_MATCH
  } step_e;

  // i-th bit of the pattern in arrival order (i = 0 is the first bit on the wire).
  function automatic bit pbit(int i);
    return PAT16[4'(PAT_LEN - 1 - i)];
  endfunction

  // Next matched-prefix length after seeing bit b with s bits already matched:
  // the longest suffix of (prefix(s), b) shorter than PAT_LEN that is a pattern prefix.
  // For a full match this is the longest proper border, or 0 without overlap.
  function automatic int entry_next(int s, bit b);
    int res;
    int maxk;
    res  = 0;
    maxk = (s + 1 < PAT_LEN) ? s + 1 : PAT_LEN - 1;
    for (int k = 1; k <= maxk; k++) begin
      bit ok;
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        int idx;
        bit sj;
        idx = s + 1 - k + j;
        sj  = (idx < s) ? pbit(idx) : b;
        if (sj != pbit(j)) ok = 1'b0;
      end
      if (ok) res = k;
    end
    if (s == PAT_LEN - 1 && b == pbit(s) && !OVERLAP) res = 0;
    return res;
  endfunction

  // Transition, expected-bit and last-state tables, padded to the full state
  // encoding so unused codes fall back to 0 and can never signal a match.
  logic [SW-1:0]     nxt_tbl [NSTATE][2];
  logic [NSTATE-1:0] exp_tbl;
  logic [NSTATE-1:0] last_tbl;

  for (genvar s = 0; s < NSTATE; s++) begin : g_tbl
    if (s < PAT_LEN) begin : g_live
      assign nxt_tbl[s][0] = SW'(entry_next(s, 1'b0));
      assign nxt_tbl[s][1] = SW'(entry_next(s, 1'b1));
      assign exp_tbl[s]    = pbit(s);
      assign last_tbl[s]   = (s == PAT_LEN - 1);
    end else begin : g_pad
      assign nxt_tbl[s][0] = '0;
      assign nxt_tbl[s][1] = '0;
      assign exp_tbl[s]    = 1'b0;
      assign last_tbl[s]   = 1'b0;
    end
  end

  logic [SW-1:0] state_q, state_d;
  step_e         step;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    step    = STEP_HOLD;
    state_d = state_q;
    dout    = 1'b0;
    if (!rst && din_valid) begin
      if (din == exp_tbl[state_q]) begin
        step = last_tbl[state_q] ? STEP_MATCH : STEP_ADVANCE;
      end else begin
        step = STEP_FALLBACK;
      end
      state_d = nxt_tbl[state_q][din];
      dout    = (step == STEP_MATCH);
    end
    if (clr) state_d = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dout && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // The clear only restarts pattern tracking; the count survives it.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Self-checking bench for mealy_seq_detector: directed vector table, hand-written
// corner sequences and a randomized run against a history-based reference model.
module tb_mealy_seq_detector;

`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk, rst, din, din_valid, clr;
  logic dout_ov, dout_no, dout_p6, dout_sat;
  logic [1:0] st_ov, st_no, st_sat;
  logic [2:0] st_p6;
  logic [7:0] cnt_ov, cnt_no, cnt_p6;
  logic [1:0] cnt_sat;

  mealy_seq_detector dut_ov (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .dout(dout_ov), .state_o(st_ov), .match_cnt(cnt_ov));

  mealy_seq_detector #(.OVERLAP(1'b0)) dut_no (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .dout(dout_no), .state_o(st_no), .match_cnt(cnt_no));

  mealy_seq_detector #(.PAT_LEN(6), .PATTERN(6'b110110), .OVERLAP(1'b1)) dut_p6 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .dout(dout_p6), .state_o(st_p6), .match_cnt(cnt_p6));

  mealy_seq_detector #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .dout(dout_sat), .state_o(st_sat), .match_cnt(cnt_sat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] act_dout [4];
  logic [31:0] act_st   [4];
  logic [31:0] act_cnt  [4];

  always_comb begin
    act_dout[0] = 32'(dout_ov);  act_st[0] = 32'(st_ov);  act_cnt[0] = 32'(cnt_ov);
    act_dout[1] = 32'(dout_no);  act_st[1] = 32'(st_no);  act_cnt[1] = 32'(cnt_no);
    act_dout[2] = 32'(dout_p6);  act_st[2] = 32'(st_p6);  act_cnt[2] = 32'(cnt_p6);
    act_dout[3] = 32'(dout_sat); act_st[3] = 32'(st_sat); act_cnt[3] = 32'(cnt_sat);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs settle 1 time unit later.
  task automatic drive(input bit r, input bit c, input bit v, input bit d);
    @(negedge clk);
    rst = r; clr = c; din_valid = v; din = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_cnt(int raw);
    return CNT_EN ? raw : 0;
  endfunction

  typedef struct {
    bit rst, clr, v, din;
    bit exp_dout;
    int exp_st;
    int exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit c, bit v, bit d, bit o, int s, int n);
    vec_t x;
    x.rst = r; x.clr = c; x.v = v; x.din = d;
    x.exp_dout = o; x.exp_st = s; x.exp_cnt = n;
    return x;
  endfunction

  // Reference model: keep the valid bits seen since the last restart point and
  // derive match and state directly from suffix/prefix comparisons.
  int          mlen  [4] = '{4, 4, 6, 4};
  logic [15:0] mpat  [4] = '{16'hB, 16'hB, 16'h36, 16'hB};
  bit          mov   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int          mcmax [4] = '{255, 255, 255, 3};
  logic [15:0] mh    [4] = '{default: '0};
  int          mhl   [4] = '{default: 0};
  int          mcnt  [4] = '{default: 0};

  function automatic logic [15:0] lmask(int k);
    return (k >= 16) ? 16'hFFFF : 16'((32'd1 << k) - 1);
  endfunction

  function automatic int model_state(logic [15:0] h, int hl, logic [15:0] p, int len);
    int res;
    res = 0;
    for (int k = 1; k < len; k++)
      if (k <= hl && ((h & lmask(k)) == ((p >> (len - k)) & lmask(k)))) res = k;
    return res;
  endfunction

  initial begin
    rst = 1'b1; clr = 1'b0; din_valid = 1'b0; din = 1'b0;

    // ---------------- directed table on the default instance ----------------
    tbl.push_back(mk(1,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,1,1, 0,1,0));
    tbl.push_back(mk(0,0,1,0, 0,2,0));
    tbl.push_back(mk(0,0,1,1, 0,3,0));
    tbl.push_back(mk(0,0,1,1, 1,1,1));
    tbl.push_back(mk(0,0,1,0, 0,2,1));
    tbl.push_back(mk(0,0,1,1, 0,3,1));
    tbl.push_back(mk(0,0,1,1, 1,1,2));
    tbl.push_back(mk(0,1,0,0, 0,0,2));
    tbl.push_back(mk(0,0,1,1, 0,1,2));
    tbl.push_back(mk(0,0,1,0, 0,2,2));
    tbl.push_back(mk(0,0,1,1, 0,3,2));
    tbl.push_back(mk(0,0,1,0, 0,2,2));
    tbl.push_back(mk(0,0,1,1, 0,3,2));
    tbl.push_back(mk(0,0,1,1, 1,1,3));
    tbl.push_back(mk(0,0,0,0, 0,1,3));
    tbl.push_back(mk(0,0,0,1, 0,1,3));
    tbl.push_back(mk(0,1,0,0, 0,0,3));
    tbl.push_back(mk(0,0,1,1, 0,1,3));
    tbl.push_back(mk(0,0,1,0, 0,2,3));
    tbl.push_back(mk(0,0,1,1, 0,3,3));
    tbl.push_back(mk(1,0,1,1, 0,0,0));
    tbl.push_back(mk(0,0,1,1, 0,1,0));
    tbl.push_back(mk(0,0,1,0, 0,2,0));
    tbl.push_back(mk(0,0,1,1, 0,3,0));
    tbl.push_back(mk(0,0,1,1, 1,1,1));
    tbl.push_back(mk(0,0,1,0, 0,2,1));
    tbl.push_back(mk(0,0,1,1, 0,3,1));
    tbl.push_back(mk(0,1,0,0, 0,0,1));
    tbl.push_back(mk(0,0,1,1, 0,1,1));
    tbl.push_back(mk(0,0,1,0, 0,2,1));
    tbl.push_back(mk(0,0,1,1, 0,3,1));
    tbl.push_back(mk(0,1,1,1, 1,0,2));
    tbl.push_back(mk(0,0,1,1, 0,1,2));
    tbl.push_back(mk(0,0,1,0, 0,2,2));
    tbl.push_back(mk(0,0,1,1, 0,3,2));
    tbl.push_back(mk(1,1,1,1, 0,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].v, tbl[i].din);
      check($sformatf("tbl%0d dout", i), 32'(dout_ov), 32'(tbl[i].exp_dout));
      tick();
      check($sformatf("tbl%0d state", i), 32'(st_ov), tbl[i].exp_st);
      check($sformatf("tbl%0d cnt", i), 32'(cnt_ov), exp_cnt(tbl[i].exp_cnt));
    end

    // ---------------- non-overlapping detection ----------------
    begin
      bit seq [7] = '{1, 0, 1, 1, 0, 1, 1};
      bit hit [7] = '{0, 0, 0, 1, 0, 0, 0};
      drive(1, 0, 0, 0); tick();
      for (int i = 0; i < 7; i++) begin
        drive(0, 0, 1, seq[i]);
        check($sformatf("noov bit%0d dout", i + 1), 32'(dout_no), 32'(hit[i]));
        tick();
      end
      check("noov final state", 32'(st_no), 1);
      check("noov final cnt", 32'(cnt_no), exp_cnt(1));
    end

    // ---------------- valid gaps with random din ----------------
    begin
      bit seq [4]   = '{1, 0, 1, 1};
      int st_exp[4] = '{1, 2, 3, 1};
      drive(1, 0, 0, 0); tick();
      for (int i = 0; i < 4; i++) begin
        drive(0, 0, 1, seq[i]);
        check($sformatf("gap bit%0d dout", i + 1), 32'(dout_ov), 32'(i == 3));
        tick();
        check($sformatf("gap bit%0d state", i + 1), 32'(st_ov), st_exp[i]);
        for (int g = 0; g < 3; g++) begin
          drive(0, 0, 0, 1'($urandom % 2));
          check($sformatf("gap%0d.%0d dout", i + 1, g), 32'(dout_ov), 0);
          tick();
          check($sformatf("gap%0d.%0d state", i + 1, g), 32'(st_ov), st_exp[i]);
        end
      end
      check("gap cnt", 32'(cnt_ov), exp_cnt(1));
    end

    // ---------------- counter saturation at CNT_W=2 ----------------
    begin
      int m;
      m = 0;
      drive(1, 0, 0, 0); tick();
      for (int i = 0; i < 16; i++) begin
        bit b, hit;
        b   = (i == 0) ? 1'b1 : (i % 3 != 1);
        hit = (i % 3 == 0) && (i > 0);
        drive(0, 0, 1, b);
        check($sformatf("sat bit%0d dout", i), 32'(dout_sat), 32'(hit));
        tick();
        if (hit) begin
          m++;
          check($sformatf("sat match%0d cnt", m), 32'(cnt_sat), exp_cnt(m > 3 ? 3 : m));
        end
      end
    end

    // ---------------- randomized run against the reference model ----------------
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r, c, v, d;
      r = (cyc == 0) || ($urandom % 100 < 2);
      c = ($urandom % 100) < 4;
      v = ($urandom % 100) < 75;
      d = 1'($urandom % 2);
      drive(r, c, v, d);
      for (int k = 0; k < 4; k++) begin
        logic [15:0] h2;
        int hl2;
        bit hit;
        h2  = {mh[k][14:0], d};
        hl2 = (mhl[k] < 16) ? mhl[k] + 1 : 16;
        hit = !r && v && (hl2 >= mlen[k]) &&
              ((h2 & lmask(mlen[k])) == (mpat[k] & lmask(mlen[k])));
        check($sformatf("rand%0d dut%0d dout", cyc, k), act_dout[k], 32'(hit));
        if (r) begin
          mh[k] = '0; mhl[k] = 0; mcnt[k] = 0;
        end else begin
          if (hit && mcnt[k] < mcmax[k]) mcnt[k]++;
          if (c || (hit && !mov[k])) begin
            mh[k] = '0; mhl[k] = 0;
          end else if (v) begin
            mh[k] = h2; mhl[k] = hl2;
          end
        end
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rand%0d dut%0d state", cyc, k), act_st[k],
              model_state(mh[k], mhl[k], mpat[k], mlen[k]));
        check($sformatf("rand%0d dut%0d cnt", cyc, k), act_cnt[k], exp_cnt(mcnt[k]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mealy_seq_detector.md
Name: mealy_seq_detector

Overview:
Parametrised Mealy serial pattern detector, the successor to the fixed 3-state Mealy FSM. It detects an arbitrary PAT_LEN-bit pattern on a 1-bit serial stream, MSB first, with KMP-style partial-match fallback. Overlapping or non-overlapping detection is selectable. It adds a qualifying valid, a synchronous clear and an optional saturating match counter. It sits between a serial front end and control logic that consumes single-cycle match pulses.

Parameters:
PAT_LEN, 4, pattern length in bits; legal 2..16.
PATTERN, 4'b1011, PAT_LEN-bit pattern; PATTERN[PAT_LEN-1] is the first bit expected.
OVERLAP, 1, 1 = on match, fall back to longest proper border; 0 = fall back to state 0.
CNT_W, 8, match counter width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
din  input  1  serial data bit
din_valid  input  1  din qualifier; the FSM advances only when high
clr  input  1  synchronous clear of FSM state to 0; does not clear the counter
dout  output  1  Mealy match pulse, combinational from state, din and din_valid
state_o  output  $clog2(PAT_LEN)  current matched-prefix length, registered
match_cnt  output  CNT_W  saturating match count (see Optional Feature)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State encoding: state = number of pattern bits currently matched, 0..PAT_LEN-1. It is a registered binary value.
- Reset:
  - rst=1 at a clk edge sets state=0 and match_cnt=0.
  - dout is forced to 0 while rst=1.
  - rst has priority over clr and din_valid.
- clr=1 with rst=0: next state=0; match_cnt holds; dout is still evaluated normally in that cycle.
- din_valid=0: state holds and dout=0.
- din_valid=1, let exp = PATTERN[PAT_LEN-1-state]:
  - din==exp and state<PAT_LEN-1: next state=state+1; dout=0.
  - din==exp and state==PAT_LEN-1: dout=1 in the same cycle (zero latency).
    - Next state = OVERLAP ? B : 0, where B = longest proper border of PATTERN.
  - din!=exp: dout=0. Next state = length of the longest suffix of (matched prefix followed by din) that is also a prefix of PATTERN. It may be 0.
- Transition table: computed at elaboration by constant functions or generate loops over PATTERN. There is no runtime table memory.
- dout is purely combinational and has no register. A downstream register sees the match one cycle later.
- Default/illegal state, i.e. state>=PAT_LEN (only possible when PAT_LEN is not a power of 2): next state=0 and dout=0.
- match_cnt increments by 1 on each cycle with dout=1. It saturates at 2^CNT_W-1 and never wraps.
- Simultaneous clr and match: the dout pulse is emitted, the counter increments, and next state=0.

Optional Feature:
Macro SEQDET_MATCH_CNT_EN.
- Defined: the match_cnt register exists and behaves as above.
- Undefined: no counter logic; match_cnt is tied to all zeros. All other behaviour is identical.

Test Plan:
1. Default parameters (PATTERN=1011, OVERLAP=1). Stream 1,0,1,1,0,1,1 with valid held high -> dout=1 on bits 4 and 7 only; state_o sequence 1,2,3,1,2,3,1; match_cnt=2.
2. Same stream with OVERLAP=0 -> dout=1 on bit 4 only; state_o after bit 7 = 1; match_cnt=1.
3. Mismatch fallback: stream 1,0,1,0,1,1 -> state_o 1,2,3,2,3, then dout=1 on bit 6 with state_o→1.
4. valid gaps: stream 1,0,1,1 with din_valid=0 for 3 cycles between each bit, din toggling randomly in the gaps -> state_o is frozen during the gaps; a single dout pulse occurs on the 4th valid bit.
5. Control priority:
   - rst mid-pattern (state_o=3) -> next cycle state_o=0, match_cnt=0, dout=0 during rst.
   - clr mid-pattern -> state_o=0 and match_cnt unchanged.
   - rst and clr asserted together -> reset result.
6. Saturation with CNT_W=2 and SEQDET_MATCH_CNT_EN defined: 5 matches -> match_cnt reads 1,2,3,3,3. With the macro undefined, match_cnt stays 0 throughout.
